cla_addsub_pipe: RTL and testbench
==================================

// Module: cla_addsub_pipe
// PURPOSE
//  Parametrised, pipelined carry-lookahead adder/subtractor; successor to the fixed 32-bit combinational CLA.
//  Splits a WIDTH-bit add/sub into WIDTH/BLK lookahead groups, one group per pipeline stage.
//  Carry ripples between stages through registers. Valid/ready handshakes on both sides.
//  Produces correct zero/negative/carry/overflow flags. Sits between the ALU operand mux and the writeback register.
// PARAMETERS
//  WIDTH  32  operand/result width; must be a multiple of BLK, else elaboration error
//  BLK     8  bits per lookahead group = bits resolved per stage (1..16)
// PORTS
//  clk        in   1      single clock, rising edge
//  rst        in   1      synchronous reset, active-high
//  in_valid   in   1      operands and op presented
//  in_ready   out  1      block accepts this cycle (in_valid & in_ready = accept)
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  op         in   2      00 ADD, 01 SUB, 10 ADC, 11 SBB
//  cin        in   1      carry-in; used by ADC/SBB only
//  out_valid  out  1      result valid
//  out_ready  in   1      consumer accepts result
//  sum        out  WIDTH  result
//  cout       out  1      carry-out of MSB (for SUB: 1 = no borrow)
//  zero       out  1      sum == 0
//  neg        out  1      sum[WIDTH-1]
//  ovf        out  1      signed overflow
// BEHAVIOUR
//  - Operand prep at accept: b_eff = op[0] ? ~b : b. c0 values:
//    - ADD: c0 = 0
//    - SUB: c0 = 1
//    - ADC: c0 = cin
//    - SBB: c0 = cin (cin = 1 means no borrow)
//  - Pipeline: NS = WIDTH/BLK stages. Stage k computes bits [k*BLK +: BLK] with full lookahead from its registered carry.
//    - Stage k forwards the partial sum, the unresolved operand bits and its group carry-out to stage k+1.
//  - Latency: exactly NS cycles from accept to out_valid with no stall (4 at defaults). Throughput 1 op/cycle.
//  - Stall: advance = ~out_valid | out_ready; all stages move together only on advance.
//    - in_ready = advance, combinational from out_ready.
//    - Bubbles (valid = 0) propagate like data, so they are not compressed.
//  - Output hold: while out_valid & ~out_ready, sum and all flags are held stable.
//  - Flags are computed in the final stage and registered with sum:
//    - ovf = (a[MSB] == b_eff[MSB]) & (sum[MSB] != a[MSB])
//    - zero covers all WIDTH bits
//  - Width rules: internal sums are BLK+1 bits; cout is the final group carry; no truncation warnings are permitted.
//  - Reset: every stage valid flag clears to 0.
//    - Reset values: out_valid = 0, sum = 0, cout/zero/neg/ovf = 0, in_ready = 1 after the reset cycle.
//  - Reset mid-operation discards all in-flight ops; no output is produced for them.
//  - in_valid during rst is ignored.
//  - Simultaneous accept and output consume in one cycle is legal and is the steady state.
// STRUCTURE
//  - Shared package alu_pkg:
//    - op encodings OP_ADD/OP_SUB/OP_ADC/OP_SBB (2-bit localparams)
//    - a flag-bundle typedef {cout, zero, neg, ovf}
//  - Sub-module cla_group #(BLK): combinational p/g generation, lookahead carries, BLK sum bits, group cout.
//    - Instantiated once per stage via generate.
//  - Top: operand prep, generate loop of stage registers, handshake control, flag logic.
// TESTING (WIDTH=32, BLK=8 unless noted)
//  - ADD 0x0000_0001 + 0xFFFF_FFFF, no stall -> after 4 cycles sum=0, cout=1, zero=1, neg=0, ovf=0.
//  - SUB 0x8000_0000 - 0x0000_0001 -> sum=0x7FFF_FFFF, ovf=1, cout=1, neg=0.
//    - SUB 5 - 7 -> sum=0xFFFF_FFFE, neg=1, cout=0, ovf=0.
//  - Back-to-back: 8 consecutive ADDs (i + 2*i), out_ready=1 -> 8 results on 8 consecutive cycles, in order.
//  - Backpressure: hold out_ready=0 for 5 cycles with 3 ops in flight -> in_ready=0, output held stable, no loss.
//    - Then all 3 results drain in order.
//  - 64-bit chain: ADC/SBB with cin: ADC 0xFFFF_FFFF + 0 with cin=1 -> sum=0, cout=1.
//    - SBB 0 - 0 with cin=0 -> sum=0xFFFF_FFFF, cout=0.
//  - Reset with 2 ops in flight -> out_valid stays 0, no stale result.
//    - Also repeat the random-vector check (10k ops vs. a behavioural model) with WIDTH=16, BLK=4.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: add/sub opcode encodings and the result flag bundle.
package alu_pkg;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_ADC = 2'b10;
   localparam logic [1:0] OP_SBB = 2'b11;

   typedef struct packed {
      logic cout;
      logic zero;
      logic neg;
      logic ovf;
   } alu_flags_t;

endpackage

// File: rtl/cla_group.sv
// One carry-lookahead group: BLK sum bits plus the group carry-out in sum_o[BLK].
module cla_group #(
   parameter int unsigned BLK = 8
) (
   input  logic [BLK-1:0] a_i,
   input  logic [BLK-1:0] b_i,
   input  logic           cin_i,
   output logic [BLK:0]   sum_o
);

   logic [BLK-1:0] p;
   logic [BLK-1:0] g;
   logic [BLK:0]   c;

   assign p = a_i ^ b_i;
   assign g = a_i & b_i;

   // Each carry is a flat sum of products over g/p and cin, not a ripple chain.
   always_comb begin
      logic acc;
      logic prod;
      acc  = 1'b0;
      prod = 1'b0;
      c    = '0;
      c[0] = cin_i;
      for (int i = 0; i < BLK; i++) begin
         acc  = g[i];
         prod = p[i];
         for (int j = i - 1; j >= 0; j--) begin
            acc  = acc | (prod & g[j]);
            prod = prod & p[j];
         end
         c[i+1] = acc | (prod & cin_i);
      end
   end

   assign sum_o = {c[BLK], p ^ c[BLK-1:0]};

endmodule

// File: rtl/cla_addsub_pipe.sv
// Pipelined CLA adder/subtractor: one lookahead group per stage, carry registered between
// stages, valid/ready on both sides, flags registered alongside the final sum.
module cla_addsub_pipe
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned BLK   = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [1:0]       op,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             zero,
   output logic             neg,
   output logic             ovf
);

   localparam int unsigned NS  = WIDTH / BLK;
   localparam int unsigned MSB = WIDTH - 1;

   if ((BLK < 1) || (BLK > 16) || ((WIDTH % BLK) != 0)) begin : g_bad_params
      $error("cla_addsub_pipe: WIDTH must be a multiple of BLK and BLK must be 1..16");
   end

   logic             advance;
   logic [WIDTH-1:0] b_eff;
   logic             c0;

   always_comb begin
      b_eff = op[0] ? ~b : b;
      c0    = 1'b0;
      unique case (op)
         OP_ADD:  c0 = 1'b0;
         OP_SUB:  c0 = 1'b1;
         OP_ADC:  c0 = cin;
         OP_SBB:  c0 = cin;
         default: c0 = 1'b0;
      endcase
   end

   // Register rank k holds the result of group k; rank NS-1 is the output register.
   logic             v_q [NS];
   logic [WIDTH-1:0] a_q [NS];
   logic [WIDTH-1:0] b_q [NS];
   logic [WIDTH-1:0] s_q [NS];
   logic             c_q [NS];

   logic             st_v [NS];
   logic [WIDTH-1:0] st_a [NS];
   logic [WIDTH-1:0] st_b [NS];
   logic [WIDTH-1:0] st_s [NS];
   logic             st_c [NS];

   alu_flags_t flags_d;
   alu_flags_t flags_q;

   assign advance  = ~v_q[NS-1] | out_ready;
   assign in_ready = advance;

   for (genvar k = 0; k < NS; k++) begin : g_stage
      logic [BLK:0]     grp;
      logic [WIDTH-1:0] s_d;

      if (k == 0) begin : g_head
         assign st_v[k] = in_valid;
         assign st_a[k] = a;
         assign st_b[k] = b_eff;
         assign st_s[k] = '0;
         assign st_c[k] = c0;
      end else begin : g_body
         assign st_v[k] = v_q[k-1];
         assign st_a[k] = a_q[k-1];
         assign st_b[k] = b_q[k-1];
         assign st_s[k] = s_q[k-1];
         assign st_c[k] = c_q[k-1];
      end

      cla_group #(
         .BLK (BLK)
      ) u_grp (
         .a_i   (st_a[k][k*BLK +: BLK]),
         .b_i   (st_b[k][k*BLK +: BLK]),
         .cin_i (st_c[k]),
         .sum_o (grp)
      );

      always_comb begin
         s_d                 = st_s[k];
         s_d[k*BLK +: BLK]   = grp[BLK-1:0];
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            v_q[k] <= 1'b0;
            a_q[k] <= '0;
            b_q[k] <= '0;
            s_q[k] <= '0;
            c_q[k] <= 1'b0;
         end else if (advance) begin
            v_q[k] <= st_v[k];
            a_q[k] <= st_a[k];
            b_q[k] <= st_b[k];
            s_q[k] <= s_d;
            c_q[k] <= grp[BLK];
         end
      end

      if (k == NS - 1) begin : g_flags
         assign flags_d = '{
            cout: grp[BLK],
            zero: (s_d == '0),
            neg:  s_d[MSB],
            ovf:  (st_a[k][MSB] == st_b[k][MSB]) & (s_d[MSB] != st_a[k][MSB])
         };
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         flags_q <= '0;
      end else if (advance) begin
         flags_q <= flags_d;
      end
   end

   assign out_valid = v_q[NS-1];
   assign sum       = s_q[NS-1];
   assign cout      = flags_q.cout;
   assign zero      = flags_q.zero;
   assign neg       = flags_q.neg;
   assign ovf       = flags_q.ovf;

endmodule

// File: tb/tb_cla_addsub_pipe.sv
// Self-checking bench: 32/8 instance for directed and table vectors, 16/4 instance for random ops.
module tb_cla_addsub_pipe;
   import alu_pkg::*;

   typedef struct packed {
      logic [31:0] sum;
      logic        cout;
      logic        zero;
      logic        neg;
      logic        ovf;
   } res32_t;

   typedef struct packed {
      logic [15:0] sum;
      logic        cout;
      logic        zero;
      logic        neg;
      logic        ovf;
   } res16_t;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [1:0]  op;
      logic        cin;
      res32_t      exp;
   } vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst = 1'b1;
   logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
   logic [31:0] a = '0, b = '0, sum;
   logic [1:0]  op = '0;
   logic        cin = 1'b0, cout, zero, neg, ovf;

   logic        n_in_valid = 1'b0, n_in_ready, n_out_valid, n_out_ready = 1'b1;
   logic [15:0] n_a = '0, n_b = '0, n_sum;
   logic [1:0]  n_op = '0;
   logic        n_cin = 1'b0, n_cout, n_zero, n_neg, n_ovf;

   cla_addsub_pipe #(.WIDTH(32), .BLK(8)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
      .op(op), .cin(cin), .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
      .cout(cout), .zero(zero), .neg(neg), .ovf(ovf)
   );

   cla_addsub_pipe #(.WIDTH(16), .BLK(4)) u_dut16 (
      .clk(clk), .rst(rst), .in_valid(n_in_valid), .in_ready(n_in_ready), .a(n_a), .b(n_b),
      .op(n_op), .cin(n_cin), .out_valid(n_out_valid), .out_ready(n_out_ready), .sum(n_sum),
      .cout(n_cout), .zero(n_zero), .neg(n_neg), .ovf(n_ovf)
   );

   int     checks = 0;
   int     errors = 0;
   int     cyc = 0;
   res32_t cur_exp;
   res16_t n_cur_exp;
   res32_t exp_q[$];
   res16_t nexp_q[$];
   int     pop_cyc[$];
   vec_t   vecs[11];

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %h want %h", name, got, want);
      end
   endtask

   function automatic res32_t model(input logic [31:0] ma, input logic [31:0] mb,
                                    input logic [1:0] mop, input logic mcin, input int w);
      logic [32:0] t;
      logic [31:0] mask, be;
      logic        c0;
      res32_t      r;
      mask   = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
      be     = (mop[0] ? ~mb : mb) & mask;
      c0     = mop[1] ? mcin : mop[0];
      t      = {1'b0, ma & mask} + {1'b0, be} + {32'd0, c0};
      r.sum  = t[31:0] & mask;
      r.cout = t[w];
      r.zero = (r.sum == 32'd0);
      r.neg  = r.sum[w-1];
      r.ovf  = (ma[w-1] == be[w-1]) && (r.sum[w-1] != ma[w-1]);
      return r;
   endfunction

   function automatic vec_t mk(input logic [31:0] va, input logic [31:0] vb, input logic [1:0] vop,
                               input logic vcin, input logic [31:0] s, input logic [3:0] f);
      vec_t v;
      v.a   = va;
      v.b   = vb;
      v.op  = vop;
      v.cin = vcin;
      v.exp = {s, f};
      return v;
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard: compare on output handshake, enqueue expected on input handshake.
   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         nexp_q.delete();
      end else begin
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_out32 got %h want none", sum);
            end else begin
               check("result32", {sum, cout, zero, neg, ovf}, exp_q.pop_front());
               pop_cyc.push_back(cyc);
            end
         end
         if (in_valid && in_ready) exp_q.push_back(cur_exp);
         if (n_out_valid && n_out_ready) begin
            if (nexp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_out16 got %h want none", n_sum);
            end else begin
               check("result16", {n_sum, n_cout, n_zero, n_neg, n_ovf}, nexp_q.pop_front());
            end
         end
         if (n_in_valid && n_in_ready) nexp_q.push_back(n_cur_exp);
      end
   end

   // Called at posedge+1; returns at posedge+1 after the accepting edge, in_valid left high.
   task automatic send(input logic [31:0] ta, input logic [31:0] tb, input logic [1:0] top,
                       input logic tc, input res32_t e);
      a        = ta;
      b        = tb;
      op       = top;
      cin      = tc;
      cur_exp  = e;
      in_valid = 1'b1;
      for (int n = 0; ; n++) begin
         @(negedge clk);
         if (in_ready) break;
         if (n > 50) begin
            check("accept_timeout", 64'(in_ready), 64'd1);
            break;
         end
         @(posedge clk);
         #1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drain32(input string name);
      for (int n = 0; n < 200 && (exp_q.size() != 0 || out_valid); n++) begin
         @(posedge clk);
         #1;
      end
      check(name, 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1);
   end

   initial begin
      logic [35:0] held;
      int          lat, bad, seen, sent;

      vecs[0]  = mk(32'h0000_0001, 32'hFFFF_FFFF, OP_ADD, 1'b0, 32'h0000_0000, 4'b1100);
      vecs[1]  = mk(32'h8000_0000, 32'h0000_0001, OP_SUB, 1'b0, 32'h7FFF_FFFF, 4'b1001);
      vecs[2]  = mk(32'h0000_0005, 32'h0000_0007, OP_SUB, 1'b0, 32'hFFFF_FFFE, 4'b0010);
      vecs[3]  = mk(32'hFFFF_FFFF, 32'h0000_0000, OP_ADC, 1'b1, 32'h0000_0000, 4'b1100);
      vecs[4]  = mk(32'h0000_0000, 32'h0000_0000, OP_SBB, 1'b0, 32'hFFFF_FFFF, 4'b0010);
      vecs[5]  = mk(32'h7FFF_FFFF, 32'h0000_0001, OP_ADD, 1'b0, 32'h8000_0000, 4'b0011);
      vecs[6]  = mk(32'h0000_0003, 32'h0000_0003, OP_SUB, 1'b0, 32'h0000_0000, 4'b1100);
      vecs[7]  = mk(32'h0000_0001, 32'h0000_0002, OP_ADC, 1'b1, 32'h0000_0004, 4'b0000);
      vecs[8]  = mk(32'h0000_0001, 32'h0000_0002, OP_ADD, 1'b1, 32'h0000_0003, 4'b0000);
      vecs[9]  = mk(32'h0000_000A, 32'h0000_0004, OP_SUB, 1'b0, 32'h0000_0006, 4'b1000);
      vecs[10] = mk(32'h0000_000A, 32'h0000_0004, OP_SBB, 1'b1, 32'h0000_0006, 4'b1000);

      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_sum_flags", {sum, cout, zero, neg, ovf}, 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Latency from accepting edge to out_valid.
      send(vecs[0].a, vecs[0].b, vecs[0].op, vecs[0].cin, vecs[0].exp);
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check("latency", 64'(lat), 64'd4);
      drain32("drain_latency");

      foreach (vecs[i]) send(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].cin, vecs[i].exp);
      in_valid = 1'b0;
      drain32("drain_table");

      // Back-to-back: results must come out on consecutive cycles.
      pop_cyc.delete();
      for (int i = 1; i <= 8; i++)
         send(32'(i), 32'(2 * i), OP_ADD, 1'b0, model(32'(i), 32'(2 * i), OP_ADD, 1'b0, 32));
      in_valid = 1'b0;
      drain32("drain_b2b");
      check("b2b_count", 64'(pop_cyc.size()), 64'd8);
      bad = 0;
      for (int i = 1; i < pop_cyc.size(); i++) if (pop_cyc[i] != pop_cyc[i-1] + 1) bad++;
      check("b2b_consecutive", 64'(bad), 64'd0);

      // Backpressure with 3 ops in flight.
      out_ready = 1'b0;
      send(32'h1234_5678, 32'h1111_1111, OP_ADD, 1'b0,
           model(32'h1234_5678, 32'h1111_1111, OP_ADD, 1'b0, 32));
      send(32'h0000_0010, 32'h0000_0020, OP_SUB, 1'b0,
           model(32'h0000_0010, 32'h0000_0020, OP_SUB, 1'b0, 32));
      send(32'hFFFF_0000, 32'h0001_0000, OP_ADC, 1'b1,
           model(32'hFFFF_0000, 32'h0001_0000, OP_ADC, 1'b1, 32));
      in_valid = 1'b0;
      for (int n = 0; n < 20 && !out_valid; n++) begin
         @(posedge clk);
         #1;
      end
      check("bp_out_valid", 64'(out_valid), 64'd1);
      held = {sum, cout, zero, neg, ovf};
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         check("bp_in_ready", 64'(in_ready), 64'd0);
         check("bp_hold", {sum, cout, zero, neg, ovf}, held);
      end
      out_ready = 1'b1;
      drain32("drain_bp");

      // Reset with 2 ops in flight; in_valid during reset must be ignored.
      send(32'h0000_0001, 32'h0000_0001, OP_ADD, 1'b0, model(32'd1, 32'd1, OP_ADD, 1'b0, 32));
      send(32'h0000_0002, 32'h0000_0002, OP_ADD, 1'b0, model(32'd2, 32'd2, OP_ADD, 1'b0, 32));
      rst = 1'b1;
      a   = 32'hDEAD_BEEF;
      @(posedge clk);
      #1;
      rst      = 1'b0;
      in_valid = 1'b0;
      check("midrst_sum", 64'(sum), 64'd0);
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         seen += int'(out_valid);
      end
      check("midrst_no_output", 64'(seen), 64'd0);

      // Random ops on the 16/4 instance with random backpressure.
      sent = 0;
      while (sent < 10000) begin
         n_a         = 16'($urandom);
         n_b         = 16'($urandom);
         n_op        = 2'($urandom);
         n_cin       = 1'($urandom);
         n_in_valid  = ($urandom_range(0, 3) != 0);
         n_out_ready = ($urandom_range(0, 3) != 0);
         n_cur_exp   = res16_t'({model({16'd0, n_a}, {16'd0, n_b}, n_op, n_cin, 16)} >> 0 >> 0);
         begin
            res32_t r;
            r         = model({16'd0, n_a}, {16'd0, n_b}, n_op, n_cin, 16);
            n_cur_exp = {r.sum[15:0], r.cout, r.zero, r.neg, r.ovf};
         end
         @(negedge clk);
         if (n_in_valid && n_in_ready) sent++;
         @(posedge clk);
         #1;
      end
      n_in_valid  = 1'b0;
      n_out_ready = 1'b1;
      for (int n = 0; n < 200 && (nexp_q.size() != 0 || n_out_valid); n++) begin
         @(posedge clk);
         #1;
      end
      check("drain16", 64'(nexp_q.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
